ram_arbiter: RTL and testbench

- Shares the single-port main system RAM between the 6502 CPU and a DMA requester (UART debug loader / host poke path that presets locations such as 0x0268/0x0269).
- Sits between the CPU address decoder and the RAM array inside the top level, on the clk50 domain.
- CPU accesses have fixed priority. The DMA port uses a req/ack handshake with a starvation guard that stalls the CPU through RDY.

---
 rtl/ram_arbiter_if.sv | 44 ++++
 rtl/ram_arbiter.sv | 97 +++++++++
 tb/tb_ram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the CPU/DMA/RAM environment and the RAM arbiter.
// The master side is the environment; the slave side is the arbiter.
interface ram_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic          cpu_clken;
    logic          cpu_sel;
    logic [AW-1:0] cpu_addr;
    logic          cpu_we;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rdy;

    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic          dma_we;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport master (
        output cpu_clken, cpu_sel, cpu_addr, cpu_we, cpu_wdata,
        input  cpu_rdata, cpu_rdy,
        output dma_req, dma_addr, dma_we, dma_wdata,
        input  dma_ack, dma_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );

    modport slave (
        input  cpu_clken, cpu_sel, cpu_addr, cpu_we, cpu_wdata,
        output cpu_rdata, cpu_rdy,
        input  dma_req, dma_addr, dma_we, dma_wdata,
        output dma_ack, dma_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares the single-port system RAM between the 6502 (fixed priority) and a
// req/ack DMA port, stalling the CPU through RDY when DMA is starved.
//
// state    | meaning
// IDLE     | port free; DMA may be granted when the CPU does not claim it
// DMA_DATA | DMA read data returning / ack pulse; port free for the CPU
module ram_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic          clk50,
    input  logic          reset_n,
    ram_arbiter_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, DMA_DATA = 1'b1} state_t;

    localparam logic [7:0] LIMIT = STARVE_LIMIT[7:0];

    state_t        state_q, state_d;
    logic [7:0]    starve_q, starve_d;
    logic          cpu_rdy_q, cpu_rdy_d;
    logic          dma_ack_q, dma_ack_d;
    logic          cpu_rd_q, cpu_rd_d;
    logic          dma_rd_q, dma_rd_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;
    logic          cpu_go, dma_go;

    assign cpu_go = bus.cpu_clken & bus.cpu_sel & cpu_rdy_q;
    assign dma_go = bus.dma_req & (state_q == IDLE) & ~cpu_go;

    always_comb begin
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_wdata = bus.cpu_wdata;
        bus.ram_we    = 1'b0;
        if (cpu_go) begin
            bus.ram_we = bus.cpu_we;
        end else if (dma_go) begin
            bus.ram_addr  = bus.dma_addr;
            bus.ram_wdata = bus.dma_wdata;
            bus.ram_we    = bus.dma_we;
        end
        if (!reset_n) bus.ram_we = 1'b0;
    end

    // Read data is shown straight from the RAM in its return cycle, then held.
    assign bus.cpu_rdata = cpu_rd_q ? bus.ram_rdata : cpu_rdata_q;
    assign bus.dma_rdata = dma_rd_q ? bus.ram_rdata : dma_rdata_q;
    assign bus.cpu_rdy   = cpu_rdy_q;
    assign bus.dma_ack   = dma_ack_q;

    always_comb begin
        state_d     = dma_go ? DMA_DATA : IDLE;
        dma_ack_d   = dma_go;
        cpu_rd_d    = cpu_go & ~bus.cpu_we;
        dma_rd_d    = dma_go & ~bus.dma_we;
        cpu_rdata_d = cpu_rd_q ? bus.ram_rdata : cpu_rdata_q;
        dma_rdata_d = dma_rd_q ? bus.ram_rdata : dma_rdata_q;

        starve_d = starve_q;
        if (!bus.dma_req || dma_go) begin
            starve_d = 8'd0;
        end else if (state_q == IDLE && starve_q != LIMIT) begin
            starve_d = starve_q + 8'd1;
        end

        cpu_rdy_d = cpu_rdy_q;
        if (dma_ack_q) begin
            cpu_rdy_d = 1'b1;
        end else if (starve_d == LIMIT) begin
            cpu_rdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            starve_q    <= 8'd0;
            cpu_rdy_q   <= 1'b1;
            dma_ack_q   <= 1'b0;
            cpu_rd_q    <= 1'b0;
            dma_rd_q    <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            cpu_rdy_q   <= cpu_rdy_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rd_q    <= cpu_rd_d;
            dma_rd_q    <= dma_rd_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, directed corner cases,
// then random CPU/DMA traffic against a transaction-level reference model.
module tb_ram_arbiter;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int LIMIT = 16;

    logic clk50   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk50 = ~clk50;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk50  (clk50),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk50) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram_mem[bus.ram_addr];
    end

    int checks = 0;
    int errors = 0;
    logic dma_busy_tb = 1'b0;

    always @(posedge clk50) begin
        if (reset_n) begin
            assert (!(dma_busy_tb && !bus.dma_req))
                else $error("FAIL dma_protocol: dma_req dropped before dma_ack");
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cpu_idle();
        bus.cpu_clken = 1'b0;
        bus.cpu_sel   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
    endtask

    task automatic dma_set(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.dma_req   = 1'b1;
        bus.dma_we    = we;
        bus.dma_addr  = a;
        bus.dma_wdata = d;
        dma_busy_tb   = 1'b1;
    endtask

    typedef struct {
        logic          clken;
        logic          sel;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          exp_we;
        logic [DW-1:0] exp_cpu_rdata;
    } vec_t;

    vec_t vt [8];

    // reference model state
    logic          m_rdy, m_busy, m_ack, m_cpu_pend, m_dma_pend, last_ack;
    logic [DW-1:0] m_cpu_val, m_dma_val, exp_cpu_rdata, exp_dma_rdata;
    int            m_denied;

    initial begin
        logic g_cpu, g_dma, exp_we, new_rdy, seen;
        logic [AW-1:0] exp_addr;
        int acks;

        cpu_idle();
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;

        // reset values, with a CPU write strobe that must not reach the RAM
        @(negedge clk50);
        bus.cpu_clken = 1'b1; bus.cpu_sel = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = 10'h055; bus.cpu_wdata = 8'hEE;
        #1;
        chk("rst_ram_we",    32'(bus.ram_we),    32'd0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst_dma_rdata", 32'(bus.dma_rdata), 32'd0);
        chk("rst_dma_ack",   32'(bus.dma_ack),   32'd0);
        chk("rst_cpu_rdy",   32'(bus.cpu_rdy),   32'd1);
        @(negedge clk50);
        cpu_idle();
        reset_n = 1'b1;

        vt[0] = '{1'b1, 1'b1, 1'b1, 10'h010, 8'hA5, 1'b1, 8'h00};
        vt[1] = '{1'b1, 1'b0, 1'b1, 10'h020, 8'hFF, 1'b0, 8'h00};
        vt[2] = '{1'b0, 1'b1, 1'b1, 10'h030, 8'hFF, 1'b0, 8'h00};
        vt[3] = '{1'b1, 1'b1, 1'b0, 10'h010, 8'h00, 1'b0, 8'h00};
        vt[4] = '{1'b0, 1'b0, 1'b0, 10'h3FF, 8'h00, 1'b0, 8'hA5};
        vt[5] = '{1'b1, 1'b1, 1'b1, 10'h3FF, 8'h5A, 1'b1, 8'hA5};
        vt[6] = '{1'b1, 1'b1, 1'b0, 10'h3FF, 8'h00, 1'b0, 8'hA5};
        vt[7] = '{1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h5A};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk50);
            bus.cpu_clken = vt[i].clken; bus.cpu_sel = vt[i].sel; bus.cpu_we = vt[i].we;
            bus.cpu_addr = vt[i].addr; bus.cpu_wdata = vt[i].wdata;
            #1;
            chk("tbl_ram_we",    32'(bus.ram_we),    32'(vt[i].exp_we));
            chk("tbl_ram_addr",  32'(bus.ram_addr),  32'(vt[i].addr));
            if (vt[i].exp_we) chk("tbl_ram_wdata", 32'(bus.ram_wdata), 32'(vt[i].wdata));
            chk("tbl_cpu_rdata", 32'(bus.cpu_rdata), 32'(vt[i].exp_cpu_rdata));
            chk("tbl_cpu_rdy",   32'(bus.cpu_rdy),   32'd1);
        end

        // back-to-back DMA writes with the CPU idle
        @(negedge clk50); cpu_idle(); dma_set(1'b1, 10'h268, 8'h34); #1;
        chk("dw1_ram_we",    32'(bus.ram_we),    32'd1);
        chk("dw1_ram_addr",  32'(bus.ram_addr),  32'h268);
        chk("dw1_ram_wdata", 32'(bus.ram_wdata), 32'h34);
        chk("dw1_ack_early", 32'(bus.dma_ack),   32'd0);
        @(negedge clk50); #1;
        chk("dw1_ack",       32'(bus.dma_ack),   32'd1);
        chk("dw1_data_we",   32'(bus.ram_we),    32'd0);
        dma_busy_tb = 1'b0;
        @(negedge clk50); dma_set(1'b1, 10'h269, 8'h12); #1;
        chk("dw2_ram_we",    32'(bus.ram_we),    32'd1);
        chk("dw2_ram_addr",  32'(bus.ram_addr),  32'h269);
        chk("dw2_ack_early", 32'(bus.dma_ack),   32'd0);
        @(negedge clk50); #1;
        chk("dw2_ack",       32'(bus.dma_ack),   32'd1);
        dma_busy_tb = 1'b0;
        @(negedge clk50); bus.dma_req = 1'b0; #1;
        chk("dw_ack_off",    32'(bus.dma_ack),   32'd0);
        chk("mem_268",       32'(ram_mem[10'h268]), 32'h34);
        chk("mem_269",       32'(ram_mem[10'h269]), 32'h12);

        // DMA read returns data coincident with the ack
        @(negedge clk50); dma_set(1'b0, 10'h268, 8'h00); #1;
        chk("dr_ram_we",     32'(bus.ram_we),    32'd0);
        chk("dr_ram_addr",   32'(bus.ram_addr),  32'h268);
        @(negedge clk50); #1;
        chk("dr_ack",        32'(bus.dma_ack),   32'd1);
        chk("dr_rdata",      32'(bus.dma_rdata), 32'h34);
        dma_busy_tb = 1'b0;
        @(negedge clk50); bus.dma_req = 1'b0; #1;
        chk("dr_rdata_held", 32'(bus.dma_rdata), 32'h34);

        // CPU read and DMA request in the same cycle: CPU first
        @(negedge clk50);
        bus.cpu_clken = 1'b1; bus.cpu_sel = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h269;
        dma_set(1'b1, 10'h120, 8'h66); #1;
        chk("col_cpu_addr",  32'(bus.ram_addr),  32'h269);
        chk("col_cpu_we",    32'(bus.ram_we),    32'd0);
        @(negedge clk50); cpu_idle(); #1;
        chk("col_cpu_rdata", 32'(bus.cpu_rdata), 32'h12);
        chk("col_dma_we",    32'(bus.ram_we),    32'd1);
        chk("col_dma_addr",  32'(bus.ram_addr),  32'h120);
        chk("col_ack_early", 32'(bus.dma_ack),   32'd0);
        @(negedge clk50); #1;
        chk("col_ack",       32'(bus.dma_ack),   32'd1);
        dma_busy_tb = 1'b0;
        @(negedge clk50); bus.dma_req = 1'b0;

        // starvation: CPU claims every cycle while DMA waits
        @(negedge clk50);
        bus.cpu_clken = 1'b1; bus.cpu_sel = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h100;
        dma_set(1'b1, 10'h300, 8'h77);
        for (int k = 0; k < LIMIT; k++) begin
            if (k > 0) @(negedge clk50);
            #1;
            chk("stv_rdy_high",  32'(bus.cpu_rdy), 32'd1);
            chk("stv_denied_we", 32'(bus.ram_we),  32'd0);
            chk("stv_no_ack",    32'(bus.dma_ack), 32'd0);
        end
        @(negedge clk50); #1;
        chk("stv_rdy_low",   32'(bus.cpu_rdy),  32'd0);
        chk("stv_grant_we",  32'(bus.ram_we),   32'd1);
        chk("stv_grant_adr", 32'(bus.ram_addr), 32'h300);
        @(negedge clk50); #1;
        chk("stv_ack",       32'(bus.dma_ack),  32'd1);
        chk("stv_rdy_ack",   32'(bus.cpu_rdy),  32'd0);
        chk("stv_stall_we",  32'(bus.ram_we),   32'd0);
        dma_busy_tb = 1'b0;
        @(negedge clk50); bus.dma_req = 1'b0; #1;
        chk("stv_rdy_back",  32'(bus.cpu_rdy),  32'd1);
        chk("stv_cpu_addr",  32'(bus.ram_addr), 32'h100);
        chk("mem_300",       32'(ram_mem[10'h300]), 32'h77);

        // reset during DMA_DATA drops the transfer; request is re-served once
        @(negedge clk50); cpu_idle(); dma_set(1'b1, 10'h0AA, 8'h99); #1;
        chk("rmo_grant",     32'(bus.ram_we),    32'd1);
        @(negedge clk50); reset_n = 1'b0; #1;
        chk("rmo_no_ack",    32'(bus.dma_ack),   32'd0);
        chk("rmo_rdy",       32'(bus.cpu_rdy),   32'd1);
        chk("rmo_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rmo_dma_rdata", 32'(bus.dma_rdata), 32'd0);
        chk("rmo_ram_we",    32'(bus.ram_we),    32'd0);
        @(negedge clk50);
        @(negedge clk50); reset_n = 1'b1; #1;
        chk("rmo_regrant",   32'(bus.ram_we),    32'd1);
        chk("rmo_re_addr",   32'(bus.ram_addr),  32'h0AA);
        acks = 0; seen = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk50);
            if (seen) bus.dma_req = 1'b0;
            #1;
            if (bus.dma_ack) begin
                acks++;
                seen = 1'b1;
                dma_busy_tb = 1'b0;
            end
        end
        chk("rmo_one_ack", 32'(acks), 32'd1);
        bus.dma_req = 1'b0;

        // random traffic against the reference model
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = ram_mem[i];
        m_rdy = 1'b1; m_busy = 1'b0; m_ack = 1'b0; m_denied = 0;
        m_cpu_pend = 1'b0; m_dma_pend = 1'b0; last_ack = 1'b0;
        m_cpu_val = '0; m_dma_val = '0;
        exp_cpu_rdata = 8'h00; exp_dma_rdata = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk50);
            bus.cpu_clken = ($urandom_range(0, 9) < 8);
            bus.cpu_sel   = ($urandom_range(0, 7) != 0);
            bus.cpu_we    = 1'($urandom_range(0, 1));
            bus.cpu_addr  = AW'($urandom_range(0, 31));
            bus.cpu_wdata = DW'($urandom);
            if (!bus.dma_req) begin
                if ($urandom_range(0, 2) == 0)
                    dma_set(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
            end else if (last_ack) begin
                if ($urandom_range(0, 1) == 0)
                    dma_set(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
                else
                    bus.dma_req = 1'b0;
            end
            #1;
            g_cpu = bus.cpu_clken & bus.cpu_sel & m_rdy;
            g_dma = bus.dma_req & !m_busy & !g_cpu;
            exp_we   = g_cpu ? bus.cpu_we : (g_dma ? bus.dma_we : 1'b0);
            exp_addr = g_dma ? bus.dma_addr : bus.cpu_addr;
            if (m_cpu_pend) exp_cpu_rdata = m_cpu_val;
            if (m_dma_pend) exp_dma_rdata = m_dma_val;
            chk("rnd_cpu_rdy",   32'(bus.cpu_rdy),   32'(m_rdy));
            chk("rnd_dma_ack",   32'(bus.dma_ack),   32'(m_ack));
            chk("rnd_ram_we",    32'(bus.ram_we),    32'(exp_we));
            chk("rnd_ram_addr",  32'(bus.ram_addr),  32'(exp_addr));
            chk("rnd_cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cpu_rdata));
            chk("rnd_dma_rdata", 32'(bus.dma_rdata), 32'(exp_dma_rdata));
            if (exp_we)
                chk("rnd_ram_wdata", 32'(bus.ram_wdata), 32'(g_cpu ? bus.cpu_wdata : bus.dma_wdata));

            m_cpu_pend = g_cpu & !bus.cpu_we;
            m_cpu_val  = ref_mem[bus.cpu_addr];
            m_dma_pend = g_dma & !bus.dma_we;
            m_dma_val  = ref_mem[bus.dma_addr];
            if (g_cpu && bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
            else if (g_dma && bus.dma_we) ref_mem[bus.dma_addr] = bus.dma_wdata;

            if (!bus.dma_req || g_dma) m_denied = 0;
            else if (!m_busy && m_denied < LIMIT) m_denied = m_denied + 1;
            new_rdy  = m_ack ? 1'b1 : ((m_denied == LIMIT) ? 1'b0 : m_rdy);
            last_ack = bus.dma_ack;
            if (bus.dma_ack) dma_busy_tb = 1'b0;
            m_ack  = g_dma;
            m_busy = g_dma;
            m_rdy  = new_rdy;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
